// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and helpers that derive bit timing
// and baud-counter width from the clock and line-rate parameters.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Never below 1 bit so the counter always has a legal declaration.
  function automatic int baud_cnt_width(input int cpb);
    return (cpb < 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_tx_serial_if.sv
// Byte handshake between the buffered TX stage (master) and the serializer (slave),
// plus the serial line and completion pulse.
interface uart_tx_serial_if;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;
  logic       tx;
  logic       txDone;

  modport master (output txStart, output txData, input txBusy, input tx, input txDone);
  modport slave  (input txStart, input txData, output txBusy, output tx, output txDone);
endinterface

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; tick is high during the last
// count so the consumer advances on the wrapping edge. clr holds it at zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int                 CNT_W = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = !clr && (cnt_reg == LAST);
endmodule

// File: rtl/uart_tx_serial.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity
// (compiled in with UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_serial_if.slave  bus
);
  localparam int   CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic STOP_LAST    = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serial: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serial: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_serial: PARITY_ODD must be 0 or 1");
  end

  logic [2:0] state_reg;
  logic [7:0] data_reg;
  logic [2:0] bit_idx_reg;
  logic       stop_cnt_reg;
  logic       tx_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       baud_clr;
  logic       tick;

  // Counter is held cleared while idle so every frame starts on a fresh bit time.
  assign baud_clr = (state_reg == ST_IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      data_reg     <= '0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (bus.txStart) begin
            data_reg    <= bus.txData;
            bit_idx_reg <= '0;
            busy_reg    <= 1'b1;
            tx_reg      <= 1'b0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_reg    <= data_reg[0];
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= (^data_reg) ^ 1'(PARITY_ODD);
              state_reg <= ST_PARITY;
`else
              tx_reg       <= 1'b1;
              stop_cnt_reg <= 1'b0;
              state_reg    <= ST_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= data_reg[bit_idx_reg + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx_reg       <= 1'b1;
            stop_cnt_reg <= 1'b0;
            state_reg    <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt_reg == STOP_LAST) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx     = tx_reg;
  assign bus.txBusy = busy_reg;
  assign bus.txDone = done_reg;
endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial at 10 clocks per bit; dut0 uses 1 stop bit /
// even parity, dut1 uses 2 stop bits / odd parity. Build with UART_TX_PARITY_EN to cover parity.
module tb_uart_tx_serial;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P_EN = 1;
`else
  localparam int P_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serial_if bus0 ();
  uart_tx_serial_if bus1 ();

  uart_tx_serial #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  uart_tx_serial #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int u);
    return (u == 1) ? bus1.tx : bus0.tx;
  endfunction
  function automatic logic get_busy(input int u);
    return (u == 1) ? bus1.txBusy : bus0.txBusy;
  endfunction
  function automatic logic get_done(input int u);
    return (u == 1) ? bus1.txDone : bus0.txDone;
  endfunction

  task automatic set_start(input int u, input logic s, input logic [7:0] d);
    if (u == 1) begin
      bus1.txStart = s;
      bus1.txData  = d;
    end else begin
      bus0.txStart = s;
      bus0.txData  = d;
    end
  endtask

  // Entered and left on a negedge. par is the hand-computed parity bit (used only
  // when parity is compiled in). inj_cycle >= 0 pulses txStart mid-frame.
  task automatic run_frame(input int u, input logic [7:0] d, input logic par, input int nstop,
                           input int inj_cycle, input logic [7:0] inj_data);
    logic [11:0] bits;
    int nbits, len, bad_tx, bad_busy, bad_done;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    nbits     = 9;
    if (P_EN == 1) begin
      bits[9] = par;
      nbits   = 10;
    end
    nbits    = nbits + nstop;
    len      = nbits * CPB;
    bad_tx   = 0;
    bad_busy = 0;
    bad_done = 0;
    set_start(u, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    set_start(u, 1'b0, ~d);
    for (int c = 0; c < len; c++) begin
      if (c == inj_cycle) set_start(u, 1'b1, inj_data);
      else if (c == inj_cycle + 1) set_start(u, 1'b0, ~inj_data);
      if (get_tx(u) !== bits[c / CPB]) bad_tx++;
      if (get_busy(u) !== 1'b1) bad_busy++;
      if (get_done(u) !== 1'b0) bad_done++;
      @(negedge clk);
    end
    check("frame_tx_bad_cycles", 32'(bad_tx), 0);
    check("frame_busy_bad_cycles", 32'(bad_busy), 0);
    check("frame_done_early", 32'(bad_done), 0);
    check("end_busy", 32'(get_busy(u)), 0);
    check("end_done", 32'(get_done(u)), 1);
    check("end_tx", 32'(get_tx(u)), 1);
    $display("frame dut%0d data=%02h len=%0d tx_bad=%0d busy_bad=%0d", u, d, len, bad_tx, bad_busy);
  endtask

  initial begin
    int changes;
    set_start(0, 1'b0, 8'h00);
    set_start(1, 1'b0, 8'h00);

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx0", 32'(bus0.tx), 1);
    check("rst_busy0", 32'(bus0.txBusy), 0);
    check("rst_done0", 32'(bus0.txDone), 0);
    check("rst_tx1", 32'(bus1.tx), 1);
    check("rst_busy1", 32'(bus1.txBusy), 0);
    rst = 1'b1;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.tx !== 1'b1 || bus0.txBusy !== 1'b0 || bus0.txDone !== 1'b0) changes++;
      if (bus1.tx !== 1'b1 || bus1.txBusy !== 1'b0 || bus1.txDone !== 1'b0) changes++;
    end
    check("idle_after_reset", 32'(changes), 0);
    $display("reset: idle 50 cycles, changes=%0d", changes);

    run_frame(0, 8'hA5, 1'b0, 1, -1, 8'h00);

    // txStart mid-frame must be ignored and must not queue a second frame.
    run_frame(0, 8'h00, 1'b0, 1, 30, 8'h55);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.txBusy !== 1'b0 || bus0.tx !== 1'b1 || bus0.txDone !== 1'b0) changes++;
    end
    check("no_queued_frame", 32'(changes), 0);
    $display("busy rejection: idle 20 cycles, activity=%0d", changes);

    // Second frame is requested on the edge right after txBusy falls.
    run_frame(0, 8'h00, 1'b0, 1, -1, 8'h00);
    run_frame(0, 8'h55, 1'b0, 1, -1, 8'h00);

    run_frame(0, 8'h07, 1'b1, 1, -1, 8'h00);
    run_frame(1, 8'h07, 1'b0, 2, -1, 8'h00);
    run_frame(1, 8'hFF, 1'b1, 2, -1, 8'h00);

    // Reset mid-frame, asserted between clock edges.
    set_start(0, 1'b1, 8'h96);
    @(posedge clk);
    @(negedge clk);
    set_start(0, 1'b0, 8'h00);
    repeat (45) @(negedge clk);
    check("midframe_busy_before", 32'(bus0.txBusy), 1);
    #2 rst = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(bus0.tx), 1);
    check("midframe_rst_busy", 32'(bus0.txBusy), 0);
    check("midframe_rst_done", 32'(bus0.txDone), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_done", 32'(bus0.txDone), 0);
    check("after_rst_tx", 32'(bus0.tx), 1);
    $display("reset mid-frame: tx=%0b busy=%0b", bus0.tx, bus0.txBusy);
    run_frame(0, 8'h3C, 1'b0, 1, -1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
